// File: rtl/avl_mem_arbiter.sv
// Round-robin merge of N Avalon-MM masters onto one DDR3 controller port,
// with an in-order tag FIFO that routes read returns to the issuing port.
module avl_mem_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 96,
  parameter int TAG_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          port_read_req,
  input  logic [NUM_PORTS-1:0]          port_write_req,
  input  logic [NUM_PORTS*ADDR_W-1:0]   port_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   port_wdata,
  input  logic [NUM_PORTS*DATA_W/8-1:0] port_be,
  output logic [NUM_PORTS-1:0]          port_ready,
  output logic [NUM_PORTS-1:0]          port_rdata_valid,
  output logic [DATA_W-1:0]             port_rdata,
  input  logic                          avl_ready,
  output logic                          avl_burstbegin,
  output logic                          avl_read_req,
  output logic                          avl_write_req,
  output logic [ADDR_W-1:0]             avl_addr,
  output logic [DATA_W-1:0]             avl_wdata,
  output logic [DATA_W/8-1:0]           avl_be,
  output logic [6:0]                    avl_size,
  input  logic                          avl_rdata_valid,
  input  logic [DATA_W-1:0]             avl_rdata,
  output logic                          rd_underflow
);

  localparam int BW = DATA_W / 8;
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int TW = $clog2(TAG_DEPTH);
  localparam int CW = TW + 1;

  logic                 rd_q, rd_d, wr_q, wr_d, bb_q, bb_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [BW-1:0]        be_q, be_d;
  logic [PW-1:0]        last_q, last_d;
  logic [PW-1:0]        tag_mem_q [TAG_DEPTH];
  logic [TW-1:0]        wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_PORTS-1:0] rv_q, rv_d;
  logic [DATA_W-1:0]    rdat_q, rdat_d;
  logic                 unf_q, unf_d;

  logic [NUM_PORTS-1:0] elig;
  logic                 full, load, found, gnt, w_rd, push, pop;
  logic [PW-1:0]        win, cand;
  int                   idx;

  // Pick the first eligible port after the last winner
  always_comb begin
    full  = (cnt_q == CW'(TAG_DEPTH));
    elig  = port_write_req | (port_read_req & {NUM_PORTS{~full}});
    load  = ~(rd_q | wr_q) | avl_ready;
    found = 1'b0;
    win   = '0;
    cand  = '0;
    idx   = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = int'(last_q) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      cand = PW'(idx);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    gnt  = load & found & ~reset;
    w_rd = port_read_req[win] & ~port_write_req[win];
    push = gnt & w_rd;
    pop  = avl_rdata_valid & (cnt_q != '0);
  end

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    bb_d    = gnt;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    last_d  = last_q;
    if (load) begin
      rd_d = gnt & w_rd;
      wr_d = gnt & ~w_rd;
    end
    if (gnt) begin
      addr_d  = port_addr[int'(win)*ADDR_W +: ADDR_W];
      wdata_d = port_wdata[int'(win)*DATA_W +: DATA_W];
      be_d    = port_be[int'(win)*BW +: BW];
      last_d  = win;
    end
  end

  always_comb begin
    wp_d   = wp_q + TW'(push);
    rp_d   = rp_q + TW'(pop);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    rv_d   = pop ? (NUM_PORTS'(1) << tag_mem_q[rp_q]) : '0;
    rdat_d = avl_rdata_valid ? avl_rdata : rdat_q;
    unf_d  = unf_q | (avl_rdata_valid & (cnt_q == '0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      bb_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      last_q  <= PW'(NUM_PORTS - 1);
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      rv_q    <= '0;
      rdat_q  <= '0;
      unf_q   <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      bb_q    <= bb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      last_q  <= last_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      rdat_q  <= rdat_d;
      unf_q   <= unf_d;
    end
  end

  // Tag storage needs no reset; occupancy is tracked by cnt_q
  always_ff @(posedge clk) begin
    if (push) tag_mem_q[wp_q] <= win;
  end

  assign port_ready       = gnt ? (NUM_PORTS'(1) << win) : '0;
  assign port_rdata_valid = rv_q;
  assign port_rdata       = rdat_q;
  assign avl_burstbegin   = bb_q;
  assign avl_read_req     = rd_q;
  assign avl_write_req    = wr_q;
  assign avl_addr         = addr_q;
  assign avl_wdata        = wdata_q;
  assign avl_be           = be_q;
  assign avl_size         = 7'd1;
  assign rd_underflow     = unf_q;

endmodule
